// File: rtl/flippy_bit_pkg.sv
// Shared definitions for the FlippyBit game engine: state encoding, LFSR taps and
// a priority helper used to pick one lane out of several candidates.
package flippy_bit_pkg;

    localparam int unsigned MAX_LANES = 8;

    localparam logic [1:0] S_IDLE      = 2'b00;
    localparam logic [1:0] S_PLAYING   = 2'b01;
    localparam logic [1:0] S_GAME_OVER = 2'b10;

    typedef enum logic [1:0] {
        StIdle     = S_IDLE,
        StPlaying  = S_PLAYING,
        StGameOver = S_GAME_OVER
    } state_e;

    // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [MAX_LANES-1:0] lowest_set(input logic [MAX_LANES-1:0] req);
        logic [MAX_LANES-1:0] sel;
        sel = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/flippy_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; supplies pseudo-random letters whose value
// depends on how long the machine ran before the game started.
module flippy_lfsr16
    import flippy_bit_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/flippy_bit_engine.sv
// FlippyBit game loop: spawns falling letters into lanes on a tick cadence, clears
// lanes whose letter matches the switches, and tracks score, lives and game state.
module flippy_bit_engine
    import flippy_bit_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 3,
    parameter int unsigned BYTE_W      = 8,
    parameter int unsigned Y_W         = 5,
    parameter int unsigned Y_BOTTOM    = 20,
    parameter int unsigned FALL_TICKS  = 4,
    parameter int unsigned SPAWN_TICKS = 16,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned LIVES       = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start_button,
    input  logic [BYTE_W-1:0]             user_bits,
    input  logic                          tick,
    output logic [1:0]                    present_state,
    output logic [SCORE_W-1:0]            score,
    output logic [2:0]                    lives,
    output logic [NUM_LANES-1:0]          lane_active,
    output logic [NUM_LANES*Y_W-1:0]      y_pos,
    output logic [NUM_LANES*BYTE_W-1:0]   letter
);

    localparam int unsigned FALL_W  = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam int unsigned SPAWN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

    localparam logic [FALL_W-1:0]  FALL_LAST  = FALL_W'(FALL_TICKS - 1);
    localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_TICKS - 1);
    localparam logic [Y_W-1:0]     Y_LAST     = Y_W'(Y_BOTTOM - 1);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

    state_e                        state_q, state_d;
    logic                          start_q, start_d;
    logic [SCORE_W-1:0]            score_q, score_d;
    logic [2:0]                    lives_q, lives_d;
    logic [NUM_LANES-1:0]          lane_active_q, lane_active_d;
    logic [NUM_LANES*Y_W-1:0]      y_q, y_d;
    logic [NUM_LANES*BYTE_W-1:0]   letter_q, letter_d;
    logic [FALL_W-1:0]             fall_cnt_q, fall_cnt_d;
    logic [SPAWN_W-1:0]            spawn_cnt_q, spawn_cnt_d;

    logic [15:0]                   lfsr;
    logic                          start_edge;
    logic                          fall_step;
    logic                          spawn_step;
    logic [BYTE_W-1:0]             spawn_letter;
    logic [MAX_LANES-1:0]          match_req, free_req;
    logic [MAX_LANES-1:0]          match_sel, free_sel;
    logic [3:0]                    miss_cnt;
    logic                          unused_bits;

    flippy_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock    (clock),
        .reset_n  (reset_n),
        .lfsr_out (lfsr)
    );

    assign start_edge   = start_button & ~start_q;
    assign fall_step    = tick && (fall_cnt_q == FALL_LAST);
    assign spawn_step   = tick && (spawn_cnt_q == SPAWN_LAST);
    // A zero letter would be indistinguishable from switches at rest.
    assign spawn_letter = (lfsr[BYTE_W-1:0] == '0) ? BYTE_W'(1) : lfsr[BYTE_W-1:0];

    // Free-lane mask is taken from pre-update state so a lane cleared this cycle
    // is never refilled on the same edge.
    always_comb begin
        match_req = '0;
        free_req  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            match_req[i] = lane_active_q[i] && (letter_q[i*BYTE_W +: BYTE_W] == user_bits);
            free_req[i]  = ~lane_active_q[i];
        end
        match_sel = lowest_set(match_req);
        free_sel  = lowest_set(free_req);
    end

    always_comb begin
        state_d       = state_q;
        start_d       = start_button;
        score_d       = score_q;
        lives_d       = lives_q;
        lane_active_d = lane_active_q;
        y_d           = y_q;
        letter_d      = letter_q;
        fall_cnt_d    = fall_cnt_q;
        spawn_cnt_d   = spawn_cnt_q;
        miss_cnt      = 4'd0;

        unique case (state_q)
            StIdle, StGameOver: begin
                if (start_edge) begin
                    state_d       = StPlaying;
                    score_d       = '0;
                    lives_d       = LIVES_INIT;
                    lane_active_d = '0;
                    fall_cnt_d    = '0;
                    spawn_cnt_d   = '0;
                end
            end
            StPlaying: begin
                if (tick) begin
                    fall_cnt_d  = fall_step ? '0 : fall_cnt_q + FALL_W'(1);
                    spawn_cnt_d = spawn_step ? '0 : spawn_cnt_q + SPAWN_W'(1);
                end

                // A match takes priority over falling off the bottom on the same edge.
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    if (match_sel[i]) begin
                        lane_active_d[i]          = 1'b0;
                        y_d[i*Y_W +: Y_W]         = '0;
                    end else if (lane_active_q[i] && fall_step) begin
                        if (y_q[i*Y_W +: Y_W] == Y_LAST) begin
                            lane_active_d[i]      = 1'b0;
                            y_d[i*Y_W +: Y_W]     = '0;
                            miss_cnt              = miss_cnt + 4'd1;
                        end else begin
                            y_d[i*Y_W +: Y_W]     = y_q[i*Y_W +: Y_W] + Y_W'(1);
                        end
                    end
                end

                if (spawn_step) begin
                    for (int unsigned i = 0; i < NUM_LANES; i++) begin
                        if (free_sel[i]) begin
                            lane_active_d[i]            = 1'b1;
                            y_d[i*Y_W +: Y_W]           = '0;
                            letter_d[i*BYTE_W +: BYTE_W] = spawn_letter;
                        end
                    end
                end

                if ((|match_sel) && (score_q != {SCORE_W{1'b1}})) begin
                    score_d = score_q + SCORE_W'(1);
                end

                lives_d = (4'(lives_q) <= miss_cnt) ? 3'd0 : lives_q - miss_cnt[2:0];
                if (lives_d == 3'd0) begin
                    state_d = StGameOver;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            start_q       <= 1'b1;
            score_q       <= '0;
            lives_q       <= LIVES_INIT;
            lane_active_q <= '0;
            y_q           <= '0;
            letter_q      <= '0;
            fall_cnt_q    <= '0;
            spawn_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            lane_active_q <= lane_active_d;
            y_q           <= y_d;
            letter_q      <= letter_d;
            fall_cnt_q    <= fall_cnt_d;
            spawn_cnt_q   <= spawn_cnt_d;
        end
    end

    assign unused_bits   = ^{match_sel, free_sel, lfsr};

    assign present_state = state_q;
    assign score         = score_q;
    assign lives         = lives_q;
    assign lane_active   = lane_active_q;
    assign y_pos         = y_q;
    assign letter        = letter_q;

endmodule

// File: tb/tb_flippy_bit_engine.sv
// Randomised scoreboard bench for flippy_bit_engine against a lane-array game model.
module tb_flippy_bit_engine;

    localparam int NL = 3;
    localparam int BW = 8;
    localparam int YW = 5;
    localparam int YB = 20;
    localparam int FT = 4;
    localparam int ST = 16;
    localparam int SW = 8;
    localparam int LV = 3;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 start_button;
    logic [BW-1:0]        user_bits;
    logic                 tick;
    logic [1:0]           present_state;
    logic [SW-1:0]        score;
    logic [2:0]           lives;
    logic [NL-1:0]        lane_active;
    logic [NL*YW-1:0]     y_pos;
    logic [NL*BW-1:0]     letter;

    always #5 clock = ~clock;

    flippy_bit_engine #(
        .NUM_LANES   (NL),
        .BYTE_W      (BW),
        .Y_W         (YW),
        .Y_BOTTOM    (YB),
        .FALL_TICKS  (FT),
        .SPAWN_TICKS (ST),
        .SCORE_W     (SW),
        .LIVES       (LV),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start_button  (start_button),
        .user_bits     (user_bits),
        .tick          (tick),
        .present_state (present_state),
        .score         (score),
        .lives         (lives),
        .lane_active   (lane_active),
        .y_pos         (y_pos),
        .letter        (letter)
    );

    typedef struct packed {
        logic [1:0]       state;
        logic [SW-1:0]    score;
        logic [2:0]       lives;
        logic [NL-1:0]    active;
        logic [NL*YW-1:0] y;
        logic [NL*BW-1:0] letter;
        logic             full;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: 0 idle, 1 playing, 2 game over.
    int m_state, m_score, m_lives, m_fall, m_spawn, m_lfsr;
    bit m_start_prev;
    int m_act[NL];
    int m_y[NL];
    int m_let[NL];

    task automatic model_reset();
        m_state = 0; m_score = 0; m_lives = LV; m_fall = 0; m_spawn = 0;
        m_lfsr = 16'hACE1; m_start_prev = 1'b1;
        for (int i = 0; i < NL; i++) begin
            m_act[i] = 0; m_y[i] = 0; m_let[i] = 0;
        end
    endtask

    function automatic int next_lfsr(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 16'hFFFF;
    endfunction

    task automatic model_step(input bit rst, input bit start, input bit tck, input int user,
                              output bit full);
        int  matched, free, misses, nl;
        bit  st_edge, fall_now, spawn_now;
        full = 1'b0;
        if (!rst) begin
            model_reset();
            full = 1'b1;
            return;
        end
        st_edge = start && !m_start_prev;
        nl      = next_lfsr(m_lfsr);
        if (m_state == 1) begin
            matched = -1;
            free    = -1;
            for (int i = 0; i < NL; i++) begin
                if (matched < 0 && m_act[i] != 0 && m_let[i] == user) matched = i;
                if (free < 0 && m_act[i] == 0) free = i;
            end
            fall_now  = tck && (m_fall == FT - 1);
            spawn_now = tck && (m_spawn == ST - 1);
            if (tck) begin
                m_fall  = (m_fall + 1) % FT;
                m_spawn = (m_spawn + 1) % ST;
            end
            misses = 0;
            for (int i = 0; i < NL; i++) begin
                if (i == matched) begin
                    m_act[i] = 0; m_y[i] = 0;
                end else if (m_act[i] != 0 && fall_now) begin
                    if (m_y[i] + 1 == YB) begin
                        m_act[i] = 0; m_y[i] = 0; misses++;
                    end else begin
                        m_y[i]++;
                    end
                end
            end
            if (spawn_now && free >= 0) begin
                m_act[free] = 1;
                m_y[free]   = 0;
                m_let[free] = m_lfsr & ((1 << BW) - 1);
                if (m_let[free] == 0) m_let[free] = 1;
            end
            if (matched >= 0 && m_score < (1 << SW) - 1) m_score++;
            m_lives = (m_lives > misses) ? m_lives - misses : 0;
            if (m_lives == 0) m_state = 2;
        end else if (st_edge) begin
            m_state = 1; m_score = 0; m_lives = LV; m_fall = 0; m_spawn = 0;
            for (int i = 0; i < NL; i++) m_act[i] = 0;
        end
        m_start_prev = start;
        m_lfsr       = nl;
    endtask

    function automatic exp_t pack_exp(input bit full);
        exp_t e;
        e.state = m_state[1:0];
        e.score = m_score[SW-1:0];
        e.lives = m_lives[2:0];
        e.full  = full;
        for (int i = 0; i < NL; i++) begin
            e.active[i]           = (m_act[i] != 0);
            e.y[i*YW +: YW]       = YW'(m_y[i]);
            e.letter[i*BW +: BW]  = BW'(m_let[i]);
        end
        return e;
    endfunction

    task automatic cycle(input bit rst, input bit start, input bit tck, input logic [BW-1:0] user);
        bit full;
        @(negedge clock);
        reset_n      = rst;
        start_button = start;
        tick         = tck;
        user_bits    = user;
        model_step(rst, start, tck, int'(user), full);
        exp_q.push_back(pack_exp(full));
    endtask

    // Letter of a random active lane; with at_bottom, only lanes about to be lost.
    function automatic logic [BW-1:0] pick_active(input bit at_bottom);
        int cand[$];
        for (int i = 0; i < NL; i++) begin
            if (m_act[i] != 0 && (!at_bottom || (m_y[i] == YB - 1 && m_fall == FT - 1)))
                cand.push_back(m_let[i]);
        end
        if (cand.size() == 0) return at_bottom ? '0 : BW'($urandom);
        return BW'(cand[$urandom_range(0, cand.size() - 1)]);
    endfunction

    task automatic ensure_playing();
        if (m_state != 1) begin
            cycle(1, 0, 0, '0);
            cycle(1, 1, 0, '0);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every edge produces a registered response to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", 64'(present_state), 64'(e.state));
                check("score", 64'(score), 64'(e.score));
                check("lives", 64'(lives), 64'(e.lives));
                check("lane_active", 64'(lane_active), 64'(e.active));
                for (int i = 0; i < NL; i++) begin
                    if (e.active[i]) begin
                        check($sformatf("y_pos[%0d]", i), 64'(y_pos[i*YW +: YW]),
                              64'(e.y[i*YW +: YW]));
                        check($sformatf("letter[%0d]", i), 64'(letter[i*BW +: BW]),
                              64'(e.letter[i*BW +: BW]));
                    end
                end
                if (e.full) begin
                    check("reset_y_pos", 64'(y_pos), 64'(e.y));
                    check("reset_letter", 64'(letter), 64'(e.letter));
                end
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        start_button = 1'b1;
        tick         = 1'b0;
        user_bits    = '0;
        model_reset();

        // Reset with the button held, then keep holding: no start.
        repeat (2) cycle(0, 1, 0, '0);
        repeat (5) cycle(1, 1, 1'($urandom), BW'($urandom));
        cycle(1, 0, 0, '0);
        cycle(1, 1, 0, '0);

        // Random play.
        for (int k = 0; k < 300; k++)
            cycle(1, 1'($urandom), 1'($urandom), BW'($urandom));

        // Aggressive matching until the score saturates, then a little beyond.
        ensure_playing();
        for (int k = 0; k < 6000 && m_score < (1 << SW) - 1; k++)
            cycle(1, 0, 1, pick_active(0));
        checks++;
        if (m_score != (1 << SW) - 1) begin
            errors++;
            $display("FAIL score_saturation_reach: got %0d, expected %0d", m_score, (1 << SW) - 1);
        end
        for (int k = 0; k < 40; k++) cycle(1, 0, 1, pick_active(0));

        // No matches: lanes drop off until the game ends, then the board freezes.
        for (int k = 0; k < 3000 && m_state != 2; k++) cycle(1, 0, 1, '0);
        checks++;
        if (m_state != 2) begin
            errors++;
            $display("FAIL game_over_reach: got state %0d, expected 2", m_state);
        end
        for (int k = 0; k < 100; k++) cycle(1, 0, 1'($urandom), BW'($urandom));

        // Restart and clear letters only on the step they would be lost.
        cycle(1, 1, 0, '0);
        for (int k = 0; k < 400; k++) cycle(1, 0, 1, pick_active(1));

        // Reset in the middle of a game, button held through it.
        for (int k = 0; k < 30; k++) cycle(1, 0, 1, BW'($urandom));
        repeat (2) cycle(0, 1'($urandom), 1, BW'($urandom));
        repeat (5) cycle(1, 1, 1, '0);
        for (int k = 0; k < 60; k++)
            cycle(1, 1'($urandom), 1'($urandom), BW'($urandom));

        repeat (2) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
